// File: rtl/jellyvl_synctimer_pkg.sv
// rtl/jellyvl_synctimer_pkg.sv - command codes and frame FSM states shared by the synctimer link
//   CMD_CORRECT / CMD_RENEW : frame command bytes (soft correction / hard set)
//   state_t                 : frame assembler states (IDLE, TIME, SUM)
//   is_time_cmd()           : true for the two command bytes that open a time frame
package jellyvl_synctimer_pkg;

  localparam logic [7:0] CMD_CORRECT = 8'h00;
  localparam logic [7:0] CMD_RENEW   = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TIME = 2'd1,
    SUM  = 2'd2
  } state_t;

  function automatic logic is_time_cmd(input logic [7:0] cmd);
    return (cmd == CMD_CORRECT) || (cmd == CMD_RENEW);
  endfunction

endpackage

// File: rtl/jellyvl_synctimer_time_receiver_if.sv
// rtl/jellyvl_synctimer_time_receiver_if.sv - byte stream bundle feeding the time receiver
//   s_first : first byte (command) of a frame
//   s_data  : stream byte
//   s_valid : byte strobe, always accepted (no ready)
interface jellyvl_synctimer_time_receiver_if;

  logic       s_first;
  logic [7:0] s_data;
  logic       s_valid;

  modport master (output s_first, output s_data, output s_valid);
  modport slave  (input  s_first, input  s_data, input  s_valid);

endinterface

// File: rtl/jellyvl_synctimer_time_receiver.sv
// rtl/jellyvl_synctimer_time_receiver.sv - assembles time-sync frames from a byte stream
//   reset          : async active-low reset
//   clk            : clock
//   param_delay    : link latency added to the received time (sampled on the checksum byte)
//   param_timeout  : max idle cycles between frame bytes, 0 disables
//   s              : byte stream (first/data/valid)
//   correct_time   : received time + param_delay, held between strobes
//   correct_renew  : 1 = hard set frame, 0 = soft correction frame
//   correct_valid  : one-cycle strobe per good frame
//   stat_ok        : good-frame count (wraps)
//   stat_err       : dropped-frame count (saturates)
module jellyvl_synctimer_time_receiver
  import jellyvl_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH   = 64,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [TIMER_WIDTH-1:0]   param_delay,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  jellyvl_synctimer_time_receiver_if.slave s,
  output logic [TIMER_WIDTH-1:0]   correct_time,
  output logic                     correct_renew,
  output logic                     correct_valid,
  output logic [STAT_WIDTH-1:0]    stat_ok,
  output logic [STAT_WIDTH-1:0]    stat_err
);

  localparam int N     = TIMER_WIDTH / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IDX_W-1:0]         r_idx;
  logic [7:0]               r_sum;
  logic [TIMER_WIDTH-1:0]   r_time;
  logic                     r_renew;
  logic [TIMEOUT_WIDTH-1:0] r_gap;

  logic [TIMER_WIDTH-1:0]   r_correct_time;
  logic                     r_correct_renew;
  logic                     r_correct_valid;
  logic [STAT_WIDTH-1:0]    r_stat_ok;
  logic [STAT_WIDTH-1:0]    r_stat_err;

  logic                     w_start;
  logic                     w_timeout;
  logic                     w_load;
  logic                     w_shift;
  logic                     w_good;
  logic                     w_err;

  assign w_start = s.s_valid & s.s_first & is_time_cmd(s.s_data);

  // r_gap counts idle cycles already seen, so the current idle cycle is the
  // T-th one when r_gap == T-1. A byte in that cycle suppresses the abort.
  assign w_timeout = (param_timeout != '0) && !s.s_valid &&
                     (r_gap == param_timeout - TIMEOUT_WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_good       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_load       = 1'b1;
          w_state_next = TIME;
        end
      end
      TIME, SUM: begin
        if (s.s_valid && s.s_first) begin
          // Abort the open frame and treat this byte as a fresh command.
          w_err        = 1'b1;
          w_load       = w_start;
          w_state_next = w_start ? TIME : IDLE;
        end else if (s.s_valid) begin
          if (r_state == TIME) begin
            w_shift = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_state_next = SUM;
            end
          end else begin
            w_good       = (s.s_data == r_sum);
            w_err        = (s.s_data != r_sum);
            w_state_next = IDLE;
          end
        end else if (w_timeout) begin
          w_err        = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx           <= '0;
      r_sum           <= '0;
      r_time          <= '0;
      r_renew         <= 1'b0;
      r_gap           <= '0;
      r_correct_time  <= '0;
      r_correct_renew <= 1'b0;
      r_correct_valid <= 1'b0;
      r_stat_ok       <= '0;
      r_stat_err      <= '0;
    end else begin
      r_correct_valid <= w_good;

      if (w_load) begin
        r_idx   <= '0;
        r_sum   <= s.s_data;
        r_renew <= s.s_data[0];
      end

      if (w_shift) begin
        r_time[8*r_idx +: 8] <= s.s_data;
        r_sum                <= r_sum + s.s_data;
        r_idx                <= r_idx + 1'b1;
      end

      if (w_good) begin
        r_correct_time  <= r_time + param_delay;
        r_correct_renew <= r_renew;
        r_stat_ok       <= r_stat_ok + 1'b1;
      end

      if (w_err && !(&r_stat_err)) begin
        r_stat_err <= r_stat_err + 1'b1;
      end

      // Only advances while a frame is open and no byte arrives.
      if (s.s_valid || (w_state_next == IDLE)) begin
        r_gap <= '0;
      end else if (!(&r_gap)) begin
        r_gap <= r_gap + 1'b1;
      end
    end
  end

  assign correct_time  = r_correct_time;
  assign correct_renew = r_correct_renew;
  assign correct_valid = r_correct_valid;
  assign stat_ok       = r_stat_ok;
  assign stat_err      = r_stat_err;

endmodule

// File: doc/jellyvl_synctimer_time_receiver.md
# jellyvl_synctimer_time_receiver

Upstream feeder of the synctimer core on slave nodes. Assembles time-sync frames from an 8-bit byte stream (ring/serial link), checks the checksum, adds a fixed link-latency offset, and emits one `correct_time` / `correct_renew` / `correct_valid` pulse per good frame. Malformed, truncated or timed-out frames are dropped and counted; they never produce `correct_valid`.

## Interface
Parameters:
- `TIMER_WIDTH`, 64, time width; must be a multiple of 8 (`N = TIMER_WIDTH/8` time bytes).
- `TIMEOUT_WIDTH`, 16, width of the inter-byte gap counter.
- `STAT_WIDTH`, 16, width of the good/error frame counters.

Ports (clock and reset first):
- `reset`  input  1  asynchronous, active-low reset.
- `clk`  input  1  single clock for all logic.
- `param_delay`  input  TIMER_WIDTH  latency offset added to the received time; sampled on the checksum byte.
- `param_timeout`  input  TIMEOUT_WIDTH  maximum idle cycles between bytes of a frame; 0 disables the timeout.
- `s_first`  input  1  marks the first byte (command) of a frame.
- `s_data`  input  8  stream byte.
- `s_valid`  input  1  byte strobe; always accepted, no ready.
- `correct_time`  output  TIMER_WIDTH  received time + `param_delay` (mod 2^TIMER_WIDTH).
- `correct_renew`  output  1  1 = hard set (command 0x01), 0 = soft correction (command 0x00).
- `correct_valid`  output  1  one-cycle strobe qualifying the two outputs above.
- `stat_ok`  output  STAT_WIDTH  good-frame count, wraps.
- `stat_err`  output  STAT_WIDTH  dropped-frame count, saturates at all-ones.

## Operation
- Frame format: command byte, N time bytes LSB first, checksum byte. Checksum = 8-bit sum (mod 256) of the command byte and all N time bytes.
- FSM states:
  - IDLE: a byte with `s_valid & s_first` and command 0x00 or 0x01 -> TIME; clears the byte index, loads the checksum accumulator with the command byte, latches the renew bit.
  - Command bytes other than 0x00/0x01 are ignored silently (no error count).
  - Bytes without `s_first` in IDLE are ignored.
  - TIME: each byte is shifted into the time register at index k and added to the accumulator; after byte N-1 -> SUM.
  - SUM: the next byte is compared with the accumulator. On match: register `correct_time = time + param_delay`, drive `correct_renew`, pulse `correct_valid`, increment `stat_ok`. On mismatch: increment `stat_err`. Either way -> IDLE.
- Abort rules, applied in TIME or SUM:
  - `s_first` arriving: `stat_err`++ and the byte is processed as a fresh IDLE byte (frame restart in the same cycle).
  - Gap counter reaching `param_timeout` (if nonzero): `stat_err`++, go to IDLE.
- The gap counter clears on every accepted byte, counts only in TIME/SUM, and saturates.
- Outputs other than `correct_valid` hold their last value between strobes.

## Timing
- Reset values: `correct_time` 0, `correct_renew` 0, `correct_valid` 0, `stat_ok` 0, `stat_err` 0. FSM resets to IDLE.
- Reset asserted mid-frame discards the partial frame with no count.
- Latency: `correct_valid` is high exactly 1 cycle after the clock edge that accepts the checksum byte. The addition is registered; there is no combinational path from `s_data` to any output.
- Back-to-back frames (command byte on the cycle right after a checksum byte) are fully supported. Minimum frame length is N+2 cycles.
- Timeout: with `param_timeout = T`, the abort fires on the T-th consecutive idle cycle after the last byte. A byte arriving on that same cycle wins: it is accepted and no timeout occurs.
- Time addition wraps modulo 2^TIMER_WIDTH. `stat_ok` wraps; `stat_err` saturates.

## Structure
- Shared package `jellyvl_synctimer_pkg`: command constants `CMD_CORRECT = 8'h00` and `CMD_RENEW = 8'h01`, plus the FSM state enum (IDLE, TIME, SUM). The frame transmitter reuses these.
- Implemented as a single module; no sub-module. Contains the checksum, byte index, gap counter and stat counters.

## Test plan
- Good frame, TIMER_WIDTH=64: command 0x00, time 0x0000_0001_0000_0000, correct checksum, `param_delay` = 100 -> 1 cycle later `correct_valid` = 1, `correct_time` = 0x0000_0001_0000_0064, `correct_renew` = 0, `stat_ok` = 1.
- Renew frame with time 0xFFFF_FFFF_FFFF_FFF0 and `param_delay` = 0x20 -> `correct_renew` = 1, `correct_time` = 0x10 (wrap).
- Corrupt checksum (good value + 1) -> no `correct_valid`, `stat_err` = 1, next good frame accepted normally.
- `s_first` injected at time byte 3 -> `stat_err` = 1; the new frame decodes correctly with no lost cycle.
- `param_timeout` = 5, then a 5-cycle gap after time byte 2 -> `stat_err` = 1, FSM in IDLE. A 4-cycle gap instead -> frame completes normally.
- Three back-to-back frames, then reset asserted mid-fourth frame -> three `correct_valid` strobes; after reset all outputs read 0.
